// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module     : data_mem_responder_pkg
// Description: Shared definitions for the execute-stage memory bus.
//              Access-width encodings (must match the exec stage) and small
//              helpers to decode them.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // Access-width encodings on mem_acc_width
    localparam logic [1:0] MEM_ACC_8   = 2'b00;
    localparam logic [1:0] MEM_ACC_16  = 2'b01;
    localparam logic [1:0] MEM_ACC_32  = 2'b10;
    localparam logic [1:0] MEM_ACC_BAD = 2'b11;

    // Number of byte beats for a given access width. The reserved encoding
    // maps to 4 but is never used for an access because it faults.
    function automatic logic [2:0] acc_bytes(input logic [1:0] width);
        case (width)
            MEM_ACC_8:  return 3'd1;
            MEM_ACC_16: return 3'd2;
            MEM_ACC_32: return 3'd4;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic acc_width_ok(input logic [1:0] width);
        return (width != MEM_ACC_BAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module     : data_mem_responder_if
// Description: Execute-stage memory bus. Net names follow the exec side:
//              mem_data_out carries store data towards memory, mem_data_in
//              carries load data back to exec.
// Signals    : mem_req, mem_we, mem_addr, mem_data_out, mem_acc_width
//              (exec -> memory); mem_data_in, mem_ready, mem_fault
//              (memory -> exec)
// Modports   : master (exec side), slave (memory responder side)
// Revision   : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
    parameter int M_WIDTH = 32
);
    logic               mem_req;
    logic               mem_we;
    logic [M_WIDTH-1:0] mem_addr;
    logic [M_WIDTH-1:0] mem_data_out;
    logic [1:0]         mem_acc_width;
    logic [M_WIDTH-1:0] mem_data_in;
    logic               mem_ready;
    logic               mem_fault;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_data_out,
        output mem_acc_width,
        input  mem_data_in,
        input  mem_ready,
        input  mem_fault
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_data_out,
        input  mem_acc_width,
        output mem_data_in,
        output mem_ready,
        output mem_fault
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_byte_ram.sv
`default_nettype none
// ============================================================================
// Module     : data_mem_responder_byte_ram
// Description: MEM_BYTES x 8 data RAM. One synchronous write port and one
//              asynchronous read port sharing a single address. Contents are
//              not reset.
// Ports      : clk   - clock
//              we    - write enable (byte written on posedge)
//              addr  - byte index
//              wdata - write byte
//              rdata - combinational read of RAM[addr]
// Revision   : 1.0 - initial release
// ============================================================================
module data_mem_responder_byte_ram #(
    parameter int MEM_BYTES = 256,
    parameter int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] r_mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module     : data_mem_responder
// Description: Responder end of the execute-stage memory bus. Serves
//              byte/half/word loads and stores from a byte-addressed RAM,
//              moving one byte per cycle, little-endian. Completion is a
//              one-cycle mem_ready pulse; load data stays stable until the
//              next accepted request.
// Ports      : clk  - clock
//              rst  - synchronous reset, active-high
//              bus  - memory bus, slave modport
// Parameters : M_WIDTH    - bus width (>= 32)
//              MEM_BYTES  - RAM size in bytes, power of 2
//              EXTRA_WAIT - idle cycles between accept and first beat (0..15)
// Revision   : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int M_WIDTH    = 32,
    parameter int MEM_BYTES  = 256,
    parameter int EXTRA_WAIT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus
);

    localparam int         c_AW        = $clog2(MEM_BYTES);
    localparam logic [3:0] c_WAIT_LAST = 4'(EXTRA_WAIT - 1);

    // Responder FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    // Latched request
    logic [c_AW-1:0]      r_addr;
    logic                 r_we;
    logic [31:0]          r_wdata;
    logic [2:0]           r_nbytes;
    logic                 r_fault;

    // Counters
    logic [1:0]           r_beat;
    logic [3:0]           r_wait_cnt;

    // Registered outputs
    logic [M_WIDTH-1:0]   r_data_in;
    logic                 r_ready;
    logic                 r_mem_fault;

    // Combinational controls
    logic                 w_req_fault;
    logic                 w_beat_last;
    logic                 w_ram_we;
    logic [c_AW-1:0]      w_ram_addr;
    logic [7:0]           w_ram_wdata;
    logic [7:0]           w_ram_rdata;

    // Out-of-range address or reserved width: the request completes with a
    // fault and never touches the RAM.
    assign w_req_fault = (bus.mem_addr >= M_WIDTH'(MEM_BYTES))
                       || !acc_width_ok(bus.mem_acc_width);

    assign w_beat_last = (({1'b0, r_beat} + 3'd1) == r_nbytes);

    // Address arithmetic in c_AW bits gives the wrap past the top of RAM.
    assign w_ram_addr  = r_addr + c_AW'(r_beat);
    assign w_ram_wdata = r_wdata[{r_beat, 3'b000} +: 8];

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and RAM write strobe
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_req) begin
                    if (EXTRA_WAIT > 0) begin
                        w_state_nxt = ST_WAIT;
                    end else if (w_req_fault) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = r_fault ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Gating with rst keeps a reset edge from landing one more
                // byte of an interrupted store.
                w_ram_we = r_we && !rst;
                if (w_beat_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A request still held from the finished transfer must drop
                // before another can be accepted.
                if (!bus.mem_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: request latch, counters, load assembly, output pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_nbytes    <= '0;
            r_fault     <= 1'b0;
            r_beat      <= '0;
            r_wait_cnt  <= '0;
            r_data_in   <= '0;
            r_ready     <= 1'b0;
            r_mem_fault <= 1'b0;
        end else begin
            r_ready     <= 1'b0;
            r_mem_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.mem_req) begin
                        r_addr     <= bus.mem_addr[c_AW-1:0];
                        r_we       <= bus.mem_we;
                        r_wdata    <= bus.mem_data_out[31:0];
                        r_nbytes   <= acc_bytes(bus.mem_acc_width);
                        r_fault    <= w_req_fault;
                        r_beat     <= '0;
                        r_wait_cnt <= '0;
                        // Loads start from zero so unread upper bytes are
                        // zero-extended; faults always return zero.
                        if (!bus.mem_we || w_req_fault) begin
                            r_data_in <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 4'd1;
                end
                ST_ACCESS: begin
                    r_beat <= r_beat + 2'd1;
                    if (!r_we) begin
                        r_data_in[{r_beat, 3'b000} +: 8] <= w_ram_rdata;
                    end
                end
                ST_DONE: begin
                    r_ready     <= 1'b1;
                    r_mem_fault <= r_fault;
                end
                default: begin
                end
            endcase
        end
    end

    data_mem_responder_byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (c_AW)
    ) u_byte_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    assign bus.mem_data_in = r_data_in;
    assign bus.mem_ready   = r_ready;
    assign bus.mem_fault   = r_mem_fault;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module     : tb_data_mem_responder
// Description: Self-checking bench for data_mem_responder. Two instances:
//              u_dut0 with no extra wait, u_dut3 with three wait cycles.
//              A vector table drives requests; expected results are queued
//              when a request is driven and compared when mem_ready fires.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  width = '0;
    logic        sel3  = 1'b0;   // 1 routes requests to the EXTRA_WAIT=3 instance

    logic        w_ready;
    logic        w_fault;
    logic [31:0] w_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder_if #(.M_WIDTH(32)) bus0 ();
    data_mem_responder_if #(.M_WIDTH(32)) bus3 ();

    assign bus0.mem_req       = req & ~sel3;
    assign bus0.mem_we        = we;
    assign bus0.mem_addr      = addr;
    assign bus0.mem_data_out  = wdata;
    assign bus0.mem_acc_width = width;
    assign bus3.mem_req       = req & sel3;
    assign bus3.mem_we        = we;
    assign bus3.mem_addr      = addr;
    assign bus3.mem_data_out  = wdata;
    assign bus3.mem_acc_width = width;

    assign w_ready = sel3 ? bus3.mem_ready   : bus0.mem_ready;
    assign w_fault = sel3 ? bus3.mem_fault   : bus0.mem_fault;
    assign w_data  = sel3 ? bus3.mem_data_in : bus0.mem_data_in;

    data_mem_responder #(.M_WIDTH(32), .MEM_BYTES(256), .EXTRA_WAIT(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    data_mem_responder #(.M_WIDTH(32), .MEM_BYTES(256), .EXTRA_WAIT(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  width;
        logic [31:0] exp_data;
        logic        exp_fault;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request, hold it `hold` cycles past mem_ready, and compare
    // the popped scoreboard entry against what the DUT returns.
    task automatic run_txn(input vec_t v, input int hold, input string name);
        exp_t e;
        int   lat;
        bit   seen;
        int   pulses;
        @(negedge clk);
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        wdata = v.data;
        width = v.width;
        e.data  = v.exp_data;
        e.fault = v.exp_fault;
        e.lat   = v.exp_lat;
        sb_q.push_back(e);
        @(posedge clk);   // accept edge
        #1;
        // Scramble the request inputs: the DUT must work from its latch.
        we    = ~v.we;
        addr  = ~v.addr;
        wdata = ~v.data;
        width = ~v.width;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (w_ready) seen = 1'b1;
        end
        e = sb_q.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no mem_ready within %0d edges", name, lat);
            req = 1'b0;
            return;
        end
        check32({name, "_data"},  w_data, e.data);
        check32({name, "_fault"}, 32'(w_fault), 32'(e.fault));
        check32({name, "_lat"},   32'(lat), 32'(e.lat));
        pulses = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (w_ready) pulses++;
        end
        if (hold > 0) check32({name, "_pulses"}, 32'(pulses), 32'd1);
        req = 1'b0;
        @(posedge clk);
        #1;
        check32({name, "_ready_low"}, 32'(w_ready), 32'd0);
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [1:0] wd, input logic [31:0] ed, input logic ef,
                                input int el);
        vec_t v;
        v.we = w; v.addr = a; v.data = d; v.width = wd;
        v.exp_data = ed; v.exp_fault = ef; v.exp_lat = el;
        return v;
    endfunction

    initial begin
        // Latency with no extra wait: n + 1 edges; fault: 1 edge.
        vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 2'b10, 32'h00000000, 0, 5)); // SW
        vecs.push_back(mk(0, 32'h10,  32'h0,        2'b10, 32'hDEADBEEF, 0, 5)); // LW round trip
        vecs.push_back(mk(1, 32'h11,  32'hFFFFFFA5, 2'b00, 32'hDEADBEEF, 0, 2)); // SB keeps data_in
        vecs.push_back(mk(0, 32'h11,  32'h0,        2'b00, 32'h000000A5, 0, 2)); // LB zero-ext
        vecs.push_back(mk(0, 32'h10,  32'h0,        2'b01, 32'h0000A5EF, 0, 3)); // LH zero-ext
        vecs.push_back(mk(1, 32'hFE,  32'h44332211, 2'b10, 32'h0000A5EF, 0, 5)); // SW wraps
        vecs.push_back(mk(0, 32'hFE,  32'h0,        2'b00, 32'h00000011, 0, 2));
        vecs.push_back(mk(0, 32'hFF,  32'h0,        2'b00, 32'h00000022, 0, 2));
        vecs.push_back(mk(0, 32'h00,  32'h0,        2'b00, 32'h00000033, 0, 2));
        vecs.push_back(mk(0, 32'h01,  32'h0,        2'b00, 32'h00000044, 0, 2));
        vecs.push_back(mk(0, 32'hFE,  32'h0,        2'b10, 32'h44332211, 0, 5)); // LW wraps
        vecs.push_back(mk(0, 32'h100, 32'h0,        2'b10, 32'h00000000, 1, 1)); // addr fault
        vecs.push_back(mk(1, 32'h10,  32'h12345678, 2'b11, 32'h00000000, 1, 1)); // width fault
        vecs.push_back(mk(0, 32'h10,  32'h0,        2'b10, 32'hDEADA5EF, 0, 5)); // RAM untouched
        vecs.push_back(mk(0, 32'hFF,  32'h0,        2'b01, 32'h00003322, 0, 3)); // misaligned wrap
        vecs.push_back(mk(1, 32'h31,  32'hAAAABEEF, 2'b01, 32'h00003322, 0, 3)); // SH misaligned
        vecs.push_back(mk(0, 32'h31,  32'h0,        2'b01, 32'h0000BEEF, 0, 3));

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check32("rst_ready",  32'(bus0.mem_ready), 32'd0);
        check32("rst_fault",  32'(bus0.mem_fault), 32'd0);
        check32("rst_data",   bus0.mem_data_in,    32'd0);
        check32("rst3_ready", 32'(bus3.mem_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_txn(vecs[i], 0, $sformatf("vec%0d", i));

        // Request held for 6 cycles after ready: exactly one pulse.
        run_txn(mk(0, 32'h10, 32'h0, 2'b10, 32'hDEADA5EF, 0, 5), 6, "held_req");

        // Reset in the middle of a store: two bytes land, the rest do not.
        run_txn(mk(1, 32'h20, 32'hA0B0C0D0, 2'b10, 32'hDEADA5EF, 0, 5), 0, "pre_sw20");
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h04030201; width = 2'b10;
        @(posedge clk);   // accept
        @(posedge clk);   // byte 0
        @(posedge clk);   // byte 1
        #1;
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check32("midrst_ready", 32'(bus0.mem_ready), 32'd0);
        check32("midrst_fault", 32'(bus0.mem_fault), 32'd0);
        check32("midrst_data",  bus0.mem_data_in,    32'd0);
        rst = 1'b0;
        // Full latency here also shows the FSM came back in IDLE.
        run_txn(mk(0, 32'h20, 32'h0, 2'b10, 32'hA0B00201, 0, 5), 0, "post_rst_lw");

        // EXTRA_WAIT = 3 instance: latency EXTRA_WAIT + n + 1, fault EXTRA_WAIT + 1.
        @(negedge clk);
        sel3 = 1'b1;
        run_txn(mk(1, 32'h40,  32'hCAFEF00D, 2'b10, 32'h00000000, 0, 8), 0, "w3_sw");
        run_txn(mk(0, 32'h40,  32'h0,        2'b10, 32'hCAFEF00D, 0, 8), 0, "w3_lw");
        run_txn(mk(0, 32'h41,  32'h0,        2'b00, 32'h000000F0, 0, 5), 0, "w3_lb");
        run_txn(mk(0, 32'h200, 32'h0,        2'b10, 32'h00000000, 1, 4), 0, "w3_fault");
        run_txn(mk(0, 32'h40,  32'h0,        2'b01, 32'h0000F00D, 0, 6), 3, "w3_held");

        check32("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
